mips_multicycle_ctrl: RTL

//  Main control FSM that sequences the MIPS datapath as a multicycle machine (fetch/decode/exec/mem/wb).

---
 rtl/mips_ctrl_pkg.sv | 64 ++++++
 rtl/mem_wait_timer.sv | 37 +++
 rtl/mips_multicycle_ctrl.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control FSM: states, opcodes, mux codes and the
// control-strobe bundle.
package mips_ctrl_pkg;

  localparam int unsigned STATE_W  = 4;
  localparam int unsigned OPCODE_W = 6;

  localparam logic [3:0] S_FETCH  = 4'd0;
  localparam logic [3:0] S_DECODE = 4'd1;
  localparam logic [3:0] S_MEMADR = 4'd2;
  localparam logic [3:0] S_MEMRD  = 4'd3;
  localparam logic [3:0] S_MEMWB  = 4'd4;
  localparam logic [3:0] S_MEMWR  = 4'd5;
  localparam logic [3:0] S_EXEC   = 4'd6;
  localparam logic [3:0] S_ALUWB  = 4'd7;
  localparam logic [3:0] S_BRANCH = 4'd8;
  localparam logic [3:0] S_ADDIEX = 4'd9;
  localparam logic [3:0] S_ADDIWB = 4'd10;
  localparam logic [3:0] S_JUMP   = 4'd11;
  localparam logic [3:0] S_TRAP   = 4'd12;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [1:0] ALU_OP_ADD   = 2'b00;
  localparam logic [1:0] ALU_OP_SUB   = 2'b01;
  localparam logic [1:0] ALU_OP_FUNCT = 2'b10;

  localparam logic [1:0] PC_SRC_ALU    = 2'b00;
  localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

  localparam logic [1:0] SRCB_REGB    = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  typedef struct packed {
    logic       mem_req;
    logic       mem_we;
    logic       iord;
    logic       ir_write;
    logic       pc_en;
    logic [1:0] pc_src;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       retire;
  } ctrl_t;

  // States that hold a memory request open until mem_ready
  function automatic logic state_has_req(input logic [3:0] s);
    return (s == S_FETCH) || (s == S_MEMRD) || (s == S_MEMWR);
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts consecutive stalled memory-request cycles and flags the cycle on which the wait budget
// runs out.
module mem_wait_timer #(
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic expire
);

  localparam int unsigned CNT_W = 8;

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Stalled cycle that would take the count to MEM_TIMEOUT
  assign expire = inc && (cnt_q == CNT_W'(MEM_TIMEOUT - 1));

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS main control FSM with memory handshake and illegal-opcode / bus-timeout traps.
// Optional MIPS_CTRL_BNE_EN adds bne decoding onto the BRANCH state.
module mips_multicycle_ctrl
  import mips_ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_we,
  output logic       iord,
  output logic       ir_write,
  output logic       pc_en,
  output logic [1:0] pc_src,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic       reg_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       retire,
  output logic       illegal,
  output logic       bus_err,
  output logic [3:0] state
);

  logic [STATE_W-1:0] state_q, state_d;
  logic               illegal_q, illegal_d;
  logic               bus_err_q, bus_err_d;
  ctrl_t              ctrl, ctrl_o;
  logic               timer_clr, timer_inc, expire;
`ifdef MIPS_CTRL_BNE_EN
  logic               bne_q, bne_d;
`endif

  assign timer_inc = !rst && state_has_req(state_q) && !mem_ready;
  assign timer_clr = rst || (state_d != state_q);

  mem_wait_timer #(
    .MEM_TIMEOUT(MEM_TIMEOUT)
  ) u_timer (
    .clk   (clk),
    .rst   (rst),
    .clr   (timer_clr),
    .inc   (timer_inc),
    .expire(expire)
  );

  always_comb begin
    ctrl      = '0;
    state_d   = state_q;
    illegal_d = illegal_q;
    bus_err_d = bus_err_q;
`ifdef MIPS_CTRL_BNE_EN
    bne_d     = bne_q;
`endif
    unique case (state_q)
      S_FETCH: begin
        ctrl.mem_req   = 1'b1;
        ctrl.alu_src_b = SRCB_FOUR;
        ctrl.alu_op    = ALU_OP_ADD;
        ctrl.pc_src    = PC_SRC_ALU;
        if (mem_ready) begin
          ctrl.ir_write = 1'b1;
          ctrl.pc_en    = 1'b1;
          state_d       = S_DECODE;
        end else if (expire) begin
          state_d   = S_TRAP;
          bus_err_d = 1'b1;
        end
      end
      S_DECODE: begin
        ctrl.alu_src_b = SRCB_IMM_SH2;
        ctrl.alu_op    = ALU_OP_ADD;
`ifdef MIPS_CTRL_BNE_EN
        bne_d = (opcode == OP_BNE);
`endif
        case (opcode)
          OP_RTYPE:     state_d = S_EXEC;
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_BEQ:       state_d = S_BRANCH;
`ifdef MIPS_CTRL_BNE_EN
          OP_BNE:       state_d = S_BRANCH;
`endif
          OP_ADDI:      state_d = S_ADDIEX;
          OP_J:         state_d = S_JUMP;
          default: begin
            state_d   = S_TRAP;
            illegal_d = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALU_OP_ADD;
        state_d        = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        ctrl.mem_req = 1'b1;
        ctrl.iord    = 1'b1;
        if (mem_ready) begin
          state_d = S_MEMWB;
        end else if (expire) begin
          state_d   = S_TRAP;
          bus_err_d = 1'b1;
        end
      end
      S_MEMWB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
        ctrl.retire     = 1'b1;
        state_d         = S_FETCH;
      end
      S_MEMWR: begin
        ctrl.mem_req = 1'b1;
        ctrl.mem_we  = 1'b1;
        ctrl.iord    = 1'b1;
        if (mem_ready) begin
          ctrl.retire = 1'b1;
          state_d     = S_FETCH;
        end else if (expire) begin
          state_d   = S_TRAP;
          bus_err_d = 1'b1;
        end
      end
      S_EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_REGB;
        ctrl.alu_op    = ALU_OP_FUNCT;
        state_d        = S_ALUWB;
      end
      S_ALUWB: begin
        ctrl.reg_write = 1'b1;
        ctrl.reg_dst   = 1'b1;
        ctrl.retire    = 1'b1;
        state_d        = S_FETCH;
      end
      S_BRANCH: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_REGB;
        ctrl.alu_op    = ALU_OP_SUB;
        ctrl.pc_src    = PC_SRC_ALUOUT;
`ifdef MIPS_CTRL_BNE_EN
        ctrl.pc_en     = bne_q ? !zero : zero;
`else
        ctrl.pc_en     = zero;
`endif
        ctrl.retire    = 1'b1;
        state_d        = S_FETCH;
      end
      S_ADDIEX: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALU_OP_ADD;
        state_d        = S_ADDIWB;
      end
      S_ADDIWB: begin
        ctrl.reg_write = 1'b1;
        ctrl.retire    = 1'b1;
        state_d        = S_FETCH;
      end
      S_JUMP: begin
        ctrl.pc_src = PC_SRC_JUMP;
        ctrl.pc_en  = 1'b1;
        ctrl.retire = 1'b1;
        state_d     = S_FETCH;
      end
      S_TRAP: begin
        state_d = S_TRAP;
      end
      default: begin
        state_d = S_TRAP;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_FETCH;
      illegal_q <= 1'b0;
      bus_err_q <= 1'b0;
`ifdef MIPS_CTRL_BNE_EN
      bne_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
      bus_err_q <= bus_err_d;
`ifdef MIPS_CTRL_BNE_EN
      bne_q     <= bne_d;
`endif
    end
  end

  // Reset forces every output low, aborting any in-flight access in the same cycle
  assign ctrl_o = rst ? '0 : ctrl;

  assign mem_req    = ctrl_o.mem_req;
  assign mem_we     = ctrl_o.mem_we;
  assign iord       = ctrl_o.iord;
  assign ir_write   = ctrl_o.ir_write;
  assign pc_en      = ctrl_o.pc_en;
  assign pc_src     = ctrl_o.pc_src;
  assign alu_src_a  = ctrl_o.alu_src_a;
  assign alu_src_b  = ctrl_o.alu_src_b;
  assign alu_op     = ctrl_o.alu_op;
  assign reg_write  = ctrl_o.reg_write;
  assign reg_dst    = ctrl_o.reg_dst;
  assign mem_to_reg = ctrl_o.mem_to_reg;
  assign retire     = ctrl_o.retire;
  assign illegal    = illegal_q && !rst;
  assign bus_err    = bus_err_q && !rst;
  assign state      = rst ? S_FETCH : state_q;

endmodule
